// File: rtl/nf_uart_tx_sched_if.sv
// rtl/nf_uart_tx_sched_if.sv - UART register bus between the TX scheduler and the UART peripheral.
interface nf_uart_tx_sched_if;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;

   modport master (output addr, output we, output wd, input rd);
   modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/nf_uart_tx_sched.sv
// rtl/nf_uart_tx_sched.sv - round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
module nf_uart_tx_sched #(
   parameter int          N_REQ   = 4,
   parameter logic [15:0] DIV     = 16'd434,
   parameter logic [31:0] CR_ADDR = 32'h0,
   parameter logic [31:0] TX_ADDR = 32'h4,
   parameter logic [31:0] DR_ADDR = 32'hC,
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   input  logic                 rx_en,
   input  logic                 err_clr,
   nf_uart_tx_sched_if.master   bus,
   output logic                 busy,
   output logic                 err
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      BOOT, INIT_DR, INIT_CR, IDLE, WR_TX, WR_CR, POLL, ABORT
   } state_t;

   state_t         state;
   logic [PW-1:0]  ptr;
   logic [7:0]     hold;
   logic [15:0]    pcnt;

   logic           gnt_any;
   logic [PW-1:0]  gnt_idx;
   logic [PW-1:0]  cand;
   logic [7:0]     gnt_byte;
   logic           unused_rd;

   assign unused_rd = ^bus.rd[31:1];

   // Scan downward so the last hit kept is the nearest valid index at or after ptr.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = PW'((int'(ptr) + k) % N_REQ);
         if (req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      gnt_byte = 8'h00;
      for (int j = 0; j < N_REQ; j++) begin
         if (PW'(j) == gnt_idx) gnt_byte = req_data[8*j +: 8];
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   assign busy = (state != IDLE);

   // Bus outputs decode straight from the state register so a reset silences the bus at once.
   always_comb begin
      bus.addr = 32'h0;
      bus.we   = 1'b0;
      bus.wd   = 32'h0;
      case (state)
         INIT_DR: begin
            bus.addr = DR_ADDR;
            bus.we   = 1'b1;
            bus.wd   = {16'h0, DIV};
         end
         INIT_CR, ABORT: begin
            bus.addr = CR_ADDR;
            bus.we   = 1'b1;
            bus.wd   = {28'h0, rx_en, 1'b1, 1'b0, 1'b0};
         end
         WR_TX: begin
            bus.addr = TX_ADDR;
            bus.we   = 1'b1;
            bus.wd   = {24'h0, hold};
         end
         WR_CR: begin
            bus.addr = CR_ADDR;
            bus.we   = 1'b1;
            bus.wd   = {28'h0, rx_en, 1'b1, 1'b0, 1'b1};
         end
         POLL: begin
            bus.addr = CR_ADDR;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= BOOT;
         ptr   <= '0;
         hold  <= 8'h00;
         pcnt  <= 16'h0;
         err   <= 1'b0;
      end else begin
         // A timeout set below is the later assignment and wins over a same-cycle clear.
         if (err_clr) err <= 1'b0;
         case (state)
            BOOT:    state <= INIT_DR;
            INIT_DR: state <= INIT_CR;
            INIT_CR: state <= IDLE;
            IDLE: begin
               if (gnt_any) begin
                  hold  <= gnt_byte;
                  ptr   <= PW'((int'(gnt_idx) + 1) % N_REQ);
                  state <= WR_TX;
               end
            end
            WR_TX:   state <= WR_CR;
            WR_CR: begin
               pcnt  <= 16'h0;
               state <= POLL;
            end
            POLL: begin
               if (pcnt != 16'hFFFF) pcnt <= pcnt + 16'h1;
               // The first two poll reads may still show the stale request bit.
               if (pcnt >= 16'd2 && !bus.rd[0]) begin
                  state <= IDLE;
               end else if (pcnt == TIMEOUT) begin
                  err   <= 1'b1;
                  state <= ABORT;
               end
            end
            ABORT:   state <= IDLE;
            default: state <= BOOT;
         endcase
      end
   end

endmodule
